fifo_stats: RTL

- Parametrised synchronous FIFO, successor to the team's basic FIFO.
- Uses all DEPTH entries (extra pointer wrap bit) and exposes an exact fill level and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags.
- Adds built-in occupancy statistics (running occupancy sum, sample count, peak level), so average occupancy is computed in hardware instead of by waveform post-processing.

---
 rtl/fifo_stats_if.sv | 43 ++++
 rtl/fifo_stats.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fifo_stats_if.sv
// Handshake/status bundle between a fifo_stats instance and its user.
// Latency: none (wires only).
// Backpressure: user observes full/empty/level; the FIFO drops and flags illegal requests.
//
// Ports (via modports):
//   master : drives w_en, data_in, r_en, stat_clr; observes data/flags/statistics
//   slave  : the FIFO side, mirror image of master
interface fifo_stats_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;
  logic                  stat_clr;
  logic [ACC_WIDTH-1:0]  occ_sum;
  logic [ACC_WIDTH-1:0]  sample_cnt;
  logic [LW-1:0]         peak_level;

  modport master (
    output w_en, data_in, r_en, stat_clr,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, level,
           overflow, underflow, occ_sum, sample_cnt, peak_level
  );

  modport slave (
    input  w_en, data_in, r_en, stat_clr,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, level,
           overflow, underflow, occ_sum, sample_cnt, peak_level
  );
endinterface

// File: rtl/fifo_stats.sv
// Synchronous FIFO with exact fill level, programmable almost flags, sticky errors and occupancy statistics.
// Latency: write visible in level next cycle; read data registered, rd_valid one cycle after accepted r_en.
// Backpressure: writes while full are dropped (overflow set), reads while empty ignored (underflow set).
//
// Ports:
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus        : fifo_stats_if.slave -- requests, data, flags, level, error flags, statistics
module fifo_stats #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int ACC_WIDTH  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo_stats_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LW-1:0]         w_ptr;
  logic [LW-1:0]         r_ptr;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;

  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [ACC_WIDTH-1:0]  occ_sum_q;
  logic [ACC_WIDTH-1:0]  sample_cnt_q;
  logic [LW-1:0]         peak_q;

  // One extra pointer bit distinguishes full from empty, so all DEPTH
  // entries are usable and the difference is the exact occupancy.
  assign level  = w_ptr - r_ptr;
  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);
  assign wr_acc = bus.w_en & ~full;
  assign rd_acc = bus.r_en & ~empty;

  // Accumulator headroom check done one bit wider so the carry-out tells us
  // the add would wrap.
  logic [ACC_WIDTH:0] sum_ext;
  logic               stat_sat;
  assign sum_ext  = {1'b0, occ_sum_q} + {{(ACC_WIDTH + 1 - LW){1'b0}}, level};
  assign stat_sat = (&sample_cnt_q) | sum_ext[ACC_WIDTH];

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[w_ptr[AW-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      occ_sum_q    <= '0;
      sample_cnt_q <= '0;
      peak_q       <= '0;
    end else begin
      if (wr_acc) begin
        w_ptr <= w_ptr + 1'b1;
      end

      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        data_out_q <= mem[r_ptr[AW-1:0]];
        r_ptr      <= r_ptr + 1'b1;
      end

      if (bus.stat_clr) begin
        // Clear cycle is not itself sampled.
        overflow_q   <= 1'b0;
        underflow_q  <= 1'b0;
        occ_sum_q    <= '0;
        sample_cnt_q <= '0;
        peak_q       <= '0;
      end else begin
        if (bus.w_en && full) begin
          overflow_q <= 1'b1;
        end
        if (bus.r_en && empty) begin
          underflow_q <= 1'b1;
        end
        // Sum and count freeze together so occ_sum/sample_cnt stays a true average.
        if (!stat_sat) begin
          occ_sum_q    <= sum_ext[ACC_WIDTH-1:0];
          sample_cnt_q <= sample_cnt_q + 1'b1;
        end
        if (level > peak_q) begin
          peak_q <= level;
        end
      end
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level >= AF_LVL);
  assign bus.almost_empty = (level <= AE_LVL);
  assign bus.level        = level;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.occ_sum      = occ_sum_q;
  assign bus.sample_cnt   = sample_cnt_q;
  assign bus.peak_level   = peak_q;
endmodule
